// File: rtl/seq_compare_unit.sv
// seq_compare_unit: multi-cycle MSB-first comparator for signed or unsigned
// operands. It scans SLICE bits per clock and reports a 0/1 result
// (zero-extended to WIDTH) plus eq/gt/lt flags over a valid/ready handshake.
module seq_compare_unit #(
    parameter int WIDTH = 6,
    parameter int SLICE = 2
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       comparison,
    input  logic             signedMode,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] zLogic,
    output logic             eqFlag,
    output logic             gtFlag,
    output logic             ltFlag
);
    localparam int NUM_SLICES = WIDTH / SLICE;
    localparam int CW         = $clog2(NUM_SLICES + 1);

    // Reject parameter sets the slice scan cannot handle.
    generate
        if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : gBadParams
            $error("seq_compare_unit: WIDTH must be >= 2 and a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SCAN, DONE} stateT;
    typedef enum logic [1:0] {UNDECIDED, DEC_GT, DEC_LT} decisionT;

    stateT            stateReg, stateNext;
    logic [WIDTH-1:0] opAReg, opBReg;
    logic [2:0]       cmpReg;
    logic             signedReg;
    decisionT         decisionReg, decisionNext;
    logic             zeroAReg, zeroBReg;
    logic [CW-1:0]    countReg;
    logic [WIDTH-1:0] zLogicReg;
    logic             eqReg, gtReg, ltReg;

    logic [SLICE-1:0] sliceA, sliceB, magA, magB;
    logic             firstSlice, lastSlice;
    logic             zeroANext, zeroBNext;
    logic             eqNext, gtNext, ltNext, resultBit;

    // Slice compare: fold the current top slice into the running decision.
    always_comb begin
        sliceA     = opAReg[WIDTH-1 -: SLICE];
        sliceB     = opBReg[WIDTH-1 -: SLICE];
        firstSlice = (countReg == CW'(NUM_SLICES));
        lastSlice  = (countReg == CW'(1));
        magA       = sliceA;
        magB       = sliceB;
        // Flipping the sign bit maps two's complement order onto unsigned order.
        if (firstSlice && signedReg) begin
            magA[SLICE-1] = ~sliceA[SLICE-1];
            magB[SLICE-1] = ~sliceB[SLICE-1];
        end
        decisionNext = decisionReg;
        if (decisionReg == UNDECIDED) begin
            if (magA > magB) begin
                decisionNext = DEC_GT;
            end else if (magA < magB) begin
                decisionNext = DEC_LT;
            end
        end
        zeroANext = zeroAReg & (sliceA == '0);
        zeroBNext = zeroBReg & (sliceB == '0);
        eqNext    = (decisionNext == UNDECIDED);
        gtNext    = (decisionNext == DEC_GT);
        ltNext    = (decisionNext == DEC_LT);
        case (cmpReg)
            3'b000:  resultBit = eqNext;
            3'b001:  resultBit = gtNext;
            3'b010:  resultBit = ltNext;
            3'b011:  resultBit = zeroANext;
            3'b100:  resultBit = gtNext | eqNext;
            3'b101:  resultBit = ltNext | eqNext;
            3'b110:  resultBit = ~eqNext;
            default: resultBit = zeroBNext;
        endcase
    end

    // Next-state and handshake outputs.
    always_comb begin
        stateNext = stateReg;
        inReady   = 1'b0;
        outValid  = 1'b0;
        case (stateReg)
            IDLE: begin
                inReady = resetN;
                if (inValid) begin
                    stateNext = SCAN;
                end
            end
            SCAN: begin
                if (lastSlice) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                outValid = 1'b1;
                if (outReady) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Operand capture, slice shifting and result registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            opAReg      <= '0;
            opBReg      <= '0;
            cmpReg      <= '0;
            signedReg   <= 1'b0;
            decisionReg <= UNDECIDED;
            zeroAReg    <= 1'b0;
            zeroBReg    <= 1'b0;
            countReg    <= '0;
            zLogicReg   <= '0;
            eqReg       <= 1'b0;
            gtReg       <= 1'b0;
            ltReg       <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (inValid) begin
                        opAReg      <= a;
                        opBReg      <= b;
                        cmpReg      <= comparison;
                        signedReg   <= signedMode;
                        decisionReg <= UNDECIDED;
                        zeroAReg    <= 1'b1;
                        zeroBReg    <= 1'b1;
                        countReg    <= CW'(NUM_SLICES);
                    end
                end
                SCAN: begin
                    opAReg      <= opAReg << SLICE;
                    opBReg      <= opBReg << SLICE;
                    decisionReg <= decisionNext;
                    zeroAReg    <= zeroANext;
                    zeroBReg    <= zeroBNext;
                    countReg    <= countReg - CW'(1);
                    if (lastSlice) begin
                        zLogicReg <= {{(WIDTH-1){1'b0}}, resultBit};
                        eqReg     <= eqNext;
                        gtReg     <= gtNext;
                        ltReg     <= ltNext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign zLogic = zLogicReg;
    assign eqFlag = eqReg;
    assign gtFlag = gtReg;
    assign ltFlag = ltReg;

endmodule
